// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
// Holds the FSM state type, the RISC-V funct3 access encodings and the size decoder.
package lsu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq0,
        StWait0,
        StReq1,
        StWait1,
        StDone,
        StFault
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic       legal;
        logic [2:0] size;
    } size_info_t;

    // Stores have no unsigned variants, so BU/HU are illegal for them.
    function automatic size_info_t decode_size(input logic [2:0] f3, input logic is_store);
        size_info_t info;
        info.legal = 1'b1;
        info.size  = 3'd4;
        case (f3)
            F3_B, F3_BU: info.size = 3'd1;
            F3_H, F3_HU: info.size = 3'd2;
            F3_W:        info.size = 3'd4;
            default:     info.legal = 1'b0;
        endcase
        if (is_store && f3[2]) begin
            info.legal = 1'b0;
        end
        return info;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit.
// Merges and extends load words, and positions store data and byte enables for both words.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] word0_i,
    input  logic [31:0] word1_i,
    output logic [31:0] rdata_o,
    output logic [3:0]  be0_o,
    output logic [3:0]  be1_o,
    output logic [31:0] wdata0_o,
    output logic [31:0] wdata1_o
);

    logic [31:0] raw;
    logic [3:0]  mask;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;

    always_comb begin
        // word1 supplies the bytes that spill past the end of word0
        raw = 32'({word1_i, word0_i} >> {offset_i, 3'b000});
        case (funct3_i)
            F3_B:    rdata_o = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   rdata_o = {24'h0, raw[7:0]};
            F3_H:    rdata_o = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   rdata_o = {16'h0, raw[15:0]};
            default: rdata_o = raw;
        endcase

        case (size_i)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        be_wide  = {4'b0000, mask} << offset_i;
        wd_wide  = {32'h0, wd_i} << {offset_i, 3'b000};
        be0_o    = be_wide[3:0];
        be1_o    = be_wide[7:4];
        wdata0_o = wd_wide[31:0];
        wdata1_o = wd_wide[63:32];
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns byte/half/word accesses into word transactions,
// splitting accesses that cross a word boundary and stalling until completion.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd,
    output logic                  stall,
    output logic                  done,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_e                state_q, state_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [2:0]            f3_q, f3_d;
    logic [2:0]            size_q, size_d;
    logic [DATA_W-1:0]     wd_q, wd_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     word0_q, word0_d;
    logic [DATA_W-1:0]     word1_q, word1_d;

    size_info_t            req_info;
    logic                  split;
    logic [DM_ADDRESS-1:0] word0_addr, word1_addr;
    logic [DATA_W-1:0]     ld_data, wdata0, wdata1;
    logic [3:0]            be0, be1;

    assign req_info   = decode_size(Funct3, !MemRead);
    assign split      = (size_q == 3'd2 && addr_q[1:0] == 2'b11) ||
                        (size_q == 3'd4 && addr_q[1:0] != 2'b00);
    assign word0_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
    assign word1_addr = word0_addr + DM_ADDRESS'(4);

    lsu_align u_align (
        .offset_i (addr_q[1:0]),
        .funct3_i (f3_q),
        .size_i   (size_q),
        .wd_i     (wd_q),
        .word0_i  (word0_q),
        .word1_i  (word1_q),
        .rdata_o  (ld_data),
        .be0_o    (be0),
        .be1_o    (be1),
        .wdata0_o (wdata0),
        .wdata1_o (wdata1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            f3_q    <= '0;
            size_q  <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            word0_q <= '0;
            word1_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            size_q  <= size_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        size_d  = size_q;
        wd_d    = wd_q;
        we_d    = we_q;
        word0_d = word0_q;
        word1_d = word1_q;
        case (state_q)
            StIdle: begin
                if (MemRead || MemWrite) begin
                    addr_d  = a;
                    f3_d    = Funct3;
                    size_d  = req_info.size;
                    wd_d    = wd;
                    we_d    = !MemRead;
                    state_d = req_info.legal ? StReq0 : StFault;
                end
            end
            StReq0: begin
                if (mem_gnt) begin
                    state_d = !we_q ? StWait0 : (split ? StReq1 : StDone);
                end
            end
            StWait0: begin
                if (mem_rvalid) begin
                    word0_d = mem_rdata;
                    state_d = split ? StReq1 : StDone;
                end
            end
            StReq1: begin
                if (mem_gnt) begin
                    state_d = we_q ? StDone : StWait1;
                end
            end
            StWait1: begin
                if (mem_rvalid) begin
                    word1_d = mem_rdata;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd        = '0;
        done      = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        case (state_q)
            StReq0: begin
                mem_req  = 1'b1;
                mem_we   = we_q;
                mem_addr = word0_addr;
                if (we_q) begin
                    mem_be    = be0;
                    mem_wdata = wdata0;
                end
            end
            StReq1: begin
                mem_req  = 1'b1;
                mem_we   = we_q;
                mem_addr = word1_addr;
                if (we_q) begin
                    mem_be    = be1;
                    mem_wdata = wdata1;
                end
            end
            StDone: begin
                done = 1'b1;
                if (!we_q) begin
                    rd = ld_data;
                end
            end
            StFault: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign stall = (MemRead || MemWrite) && !done && !err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of accesses against a small word memory,
// plus a hand-driven reset-during-split-load sequence.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  a;
    logic [31:0] wd, rd;
    logic        stall, done, err;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [8:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .a          (a),
        .wd         (wd),
        .rd         (rd),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, w;
        logic [2:0]  f3;
        logic [8:0]  a;
        logic [31:0] wd;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_cyc;
        int          exp_n;
        logic [8:0]  addr0, addr1;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [0:127];

    logic [31:0] res_rd;
    logic        res_err;
    int          res_cyc, n_txn;
    logic        stall_bad, unstable, got_done;
    logic [8:0]  t_addr [2];
    logic [3:0]  t_be [2];
    logic [31:0] t_wd [2];
    logic        t_we [2];

    function automatic vec_t mk(logic r, logic w, logic [2:0] f3, logic [8:0] ad,
                                logic [31:0] d, int hold, logic [31:0] erd, logic eerr,
                                int ecyc, int en, logic [8:0] a0, logic [3:0] b0,
                                logic [31:0] w0, logic [8:0] a1, logic [3:0] b1,
                                logic [31:0] w1);
        vec_t v;
        v.r = r; v.w = w; v.f3 = f3; v.a = ad; v.wd = d; v.hold = hold;
        v.exp_rd = erd; v.exp_err = eerr; v.exp_cyc = ecyc; v.exp_n = en;
        v.addr0 = a0; v.be0 = b0; v.wd0 = w0; v.addr1 = a1; v.be1 = b1; v.wd1 = w1;
        return v;
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One access with a responsive memory; grant withheld for `hold` cycles per request.
    task automatic run_op(input logic r, input logic w, input logic [2:0] f3,
                          input logic [8:0] ad, input logic [31:0] d, input int hold);
        int          cyc = 0;
        int          held = 0;
        logic        pend = 1'b0;
        logic [6:0]  pidx = '0;
        logic [45:0] prev = '0;
        @(negedge clk);
        MemRead = r; MemWrite = w; Funct3 = f3; a = ad; wd = d;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        n_txn = 0; stall_bad = 1'b0; unstable = 1'b0; got_done = 1'b0;
        res_rd = '0; res_err = 1'b0; res_cyc = -1;
        while (!got_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (pend) begin
                mem_rvalid = 1'b1;
                mem_rdata = mem[pidx];
                pend = 1'b0;
            end
            if (done) begin
                got_done = 1'b1;
                res_rd = rd; res_err = err; res_cyc = cyc;
            end else begin
                if (!stall) stall_bad = 1'b1;
                if (mem_req) begin
                    if (held > 0 && {mem_addr, mem_be, mem_wdata, mem_we} !== prev)
                        unstable = 1'b1;
                    prev = {mem_addr, mem_be, mem_wdata, mem_we};
                    if (held < hold) begin
                        held++;
                    end else begin
                        mem_gnt = 1'b1;
                        held = 0;
                        if (n_txn < 2) begin
                            t_addr[n_txn] = mem_addr; t_be[n_txn] = mem_be;
                            t_wd[n_txn] = mem_wdata; t_we[n_txn] = mem_we;
                        end
                        n_txn++;
                        if (mem_we) begin
                            for (int i = 0; i < 4; i++)
                                if (mem_be[i]) mem[mem_addr[8:2]][8*i +: 8] = mem_wdata[8*i +: 8];
                        end else begin
                            pend = 1'b1;
                            pidx = mem_addr[8:2];
                        end
                    end
                end
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    vec_t vecs [20];

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[9'h010 >> 2] = 32'h8001_7FFE;
        mem[9'h0FC >> 2] = 32'hBBAA_1122;
        mem[9'h100 >> 2] = 32'h3344_DDCC;

        //           r     w     f3      a       wd            hold rd             err  cyc n  addr0   be0   wd0            addr1   be1   wd1
        vecs[0]  = mk(1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        0, 32'h8001_7FFE, 1'b0, 3, 1, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[1]  = mk(1'b1, 1'b0, 3'b000, 9'h013, 32'h0,        0, 32'hFFFF_FF80, 1'b0, 3, 1, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[2]  = mk(1'b1, 1'b0, 3'b100, 9'h013, 32'h0,        0, 32'h0000_0080, 1'b0, 3, 1, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[3]  = mk(1'b1, 1'b0, 3'b001, 9'h012, 32'h0,        0, 32'hFFFF_8001, 1'b0, 3, 1, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[4]  = mk(1'b1, 1'b0, 3'b101, 9'h011, 32'h0,        0, 32'h0000_017F, 1'b0, 3, 1, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[5]  = mk(1'b1, 1'b0, 3'b010, 9'h0FE, 32'h0,        0, 32'hDDCC_BBAA, 1'b0, 5, 2, 9'h0FC, 4'h0, 32'h0,        9'h100, 4'h0, 32'h0);
        vecs[6]  = mk(1'b1, 1'b0, 3'b001, 9'h0FF, 32'h0,        0, 32'hFFFF_CCBB, 1'b0, 5, 2, 9'h0FC, 4'h0, 32'h0,        9'h100, 4'h0, 32'h0);
        vecs[7]  = mk(1'b1, 1'b0, 3'b100, 9'h101, 32'h0,        0, 32'h0000_00DD, 1'b0, 3, 1, 9'h100, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[8]  = mk(1'b0, 1'b1, 3'b001, 9'h1FF, 32'h1234_5678, 0, 32'h0,        1'b0, 3, 2, 9'h1FC, 4'h8, 32'h7800_0000, 9'h000, 4'h1, 32'h0000_0056);
        vecs[9]  = mk(1'b1, 1'b0, 3'b010, 9'h1FC, 32'h0,        0, 32'h7800_0000, 1'b0, 3, 1, 9'h1FC, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[10] = mk(1'b1, 1'b0, 3'b100, 9'h000, 32'h0,        0, 32'h0000_0056, 1'b0, 3, 1, 9'h000, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[11] = mk(1'b0, 1'b1, 3'b000, 9'h005, 32'h0000_00A5, 3, 32'h0,        1'b0, 5, 1, 9'h004, 4'h2, 32'h0000_A500, 9'h0,   4'h0, 32'h0);
        vecs[12] = mk(1'b0, 1'b1, 3'b010, 9'h022, 32'h1122_3344, 0, 32'h0,        1'b0, 3, 2, 9'h020, 4'hC, 32'h3344_0000, 9'h024, 4'h3, 32'h0000_1122);
        vecs[13] = mk(1'b1, 1'b0, 3'b010, 9'h020, 32'h0,        0, 32'h3344_0000, 1'b0, 3, 1, 9'h020, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[14] = mk(1'b0, 1'b1, 3'b010, 9'h030, 32'hCAFE_F00D, 0, 32'h0,        1'b0, 2, 1, 9'h030, 4'hF, 32'hCAFE_F00D, 9'h0,   4'h0, 32'h0);
        vecs[15] = mk(1'b1, 1'b1, 3'b010, 9'h010, 32'hFFFF_FFFF, 0, 32'h8001_7FFE, 1'b0, 3, 1, 9'h010, 4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[16] = mk(1'b1, 1'b0, 3'b011, 9'h010, 32'h0,        0, 32'h0,         1'b1, 1, 0, 9'h0,   4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[17] = mk(1'b0, 1'b1, 3'b100, 9'h010, 32'h0,        0, 32'h0,         1'b1, 1, 0, 9'h0,   4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[18] = mk(1'b1, 1'b0, 3'b111, 9'h010, 32'h0,        0, 32'h0,         1'b1, 1, 0, 9'h0,   4'h0, 32'h0,        9'h0,   4'h0, 32'h0);
        vecs[19] = mk(1'b1, 1'b0, 3'b010, 9'h1FE, 32'h0,        0, 32'h0056_7800, 1'b0, 5, 2, 9'h1FC, 4'h0, 32'h0,        9'h000, 4'h0, 32'h0);

        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0; a = '0; wd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("reset rd", rd, 32'h0);
        chk("reset ctl", {28'h0, stall, done, err, mem_req}, 32'h0);
        chk("reset we/be", {27'h0, mem_we, mem_be}, 32'h0);
        chk("reset addr", {23'h0, mem_addr}, 32'h0);
        chk("reset wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].r, vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].hold);
            chk($sformatf("v%0d done-cycle", i), res_cyc, vecs[i].exp_cyc);
            chk($sformatf("v%0d rd", i), res_rd, vecs[i].exp_rd);
            chk($sformatf("v%0d err", i), {31'h0, res_err}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d txn count", i), n_txn, vecs[i].exp_n);
            chk($sformatf("v%0d stall", i), {31'h0, stall_bad}, 32'h0);
            chk($sformatf("v%0d req stable", i), {31'h0, unstable}, 32'h0);
            if (n_txn >= 1 && vecs[i].exp_n >= 1) begin
                chk($sformatf("v%0d addr0", i), {23'h0, t_addr[0]}, {23'h0, vecs[i].addr0});
                chk($sformatf("v%0d we0", i), {31'h0, t_we[0]}, {31'h0, vecs[i].w && !vecs[i].r});
                if (vecs[i].w && !vecs[i].r) begin
                    chk($sformatf("v%0d be0", i), {28'h0, t_be[0]}, {28'h0, vecs[i].be0});
                    chk($sformatf("v%0d wdata0", i), t_wd[0] & lanes(vecs[i].be0), vecs[i].wd0);
                end
            end
            if (n_txn >= 2 && vecs[i].exp_n >= 2) begin
                chk($sformatf("v%0d addr1", i), {23'h0, t_addr[1]}, {23'h0, vecs[i].addr1});
                if (vecs[i].w && !vecs[i].r) begin
                    chk($sformatf("v%0d be1", i), {28'h0, t_be[1]}, {28'h0, vecs[i].be1});
                    chk($sformatf("v%0d wdata1", i), t_wd[1] & lanes(vecs[i].be1), vecs[i].wd1);
                end
            end
            @(negedge clk);
            chk($sformatf("v%0d idle after", i), {27'h0, rd != 0, done, err, mem_req, stall}, 32'h0);
        end

        // Reset while waiting for the second word of a split load.
        @(negedge clk);
        MemRead = 1'b1; Funct3 = 3'b010; a = 9'h0FE;
        @(negedge clk);
        chk("rst seq req0", {22'h0, mem_req, mem_addr}, {22'h0, 1'b1, 9'h0FC});
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = mem[9'h0FC >> 2];
        chk("rst seq wait0", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rst seq req1", {22'h0, mem_req, mem_addr}, {22'h0, 1'b1, 9'h100});
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        reset = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        chk("rst seq idle", {29'h0, mem_req, stall, done}, 32'h0);
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = mem[9'h100 >> 2];
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rst seq late rvalid", {rd[30:0], done | mem_req}, 32'h0);
        @(negedge clk);
        chk("rst seq no done", {30'h0, done, mem_req}, 32'h0);

        run_op(1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 0);
        chk("post-reset LW rd", res_rd, 32'h8001_7FFE);
        chk("post-reset LW cycle", res_cyc, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage initiator sitting between the pipeline and the word-organised data memory.
- Converts byte/halfword/word loads and stores (RISC-V funct3 encoding) into word-aligned memory transactions with byte enables.
- Splits misaligned accesses that cross a word boundary into two word transactions and merges, or distributes, the byte lanes.
- Stalls the pipeline until the access completes.

Parameters:
- DM_ADDRESS, 9, byte-address width of data memory; word index is a[DM_ADDRESS-1:2].
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load request from the control unit; held stable while stall=1.
- MemWrite  in  1  store request; held stable while stall=1.
- Funct3  in  3  access size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- a  in  DM_ADDRESS  byte address.
- wd  in  DATA_W  store data, right-justified.
- rd  out  DATA_W  load result; valid only in the done cycle, else 0.
- stall  out  1  freezes the pipeline.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on illegal Funct3; no memory access is made.
- mem_req  out  1  transaction request; held until granted.
- mem_we  out  1  write transaction.
- mem_addr  out  DM_ADDRESS  word-aligned byte address; low 2 bits are always 00.
- mem_be  out  4  byte enables, write only.
- mem_wdata  out  32  lane-positioned write data.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt.
- mem_rdata  in  32  read word.

Behaviour:
- Reset: state IDLE. rd=0, stall=0, done=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0. All outputs are registered or decoded from registered state.
- stall is combinational: (MemRead|MemWrite) && !done && !err.
- If MemRead and MemWrite are both high, MemRead wins.
- Request capture in IDLE: when MemRead|MemWrite, latch a, Funct3, wd and the direction.
  - Illegal Funct3 (011, 110, 111; stores only 000/001/010 legal): go to FAULT. The err and done pulse is issued one cycle later.
- Split rule:
  - Split when (size=2 && a[1:0]==11) or (size=4 && a[1:0]!=00).
  - Word 0 address = {a[DM_ADDRESS-1:2],00}.
  - Word 1 address = word 0 + 4, modulo 2^DM_ADDRESS (wraps to 0).
- States: IDLE -> REQ0 -> (WAIT0 for loads) -> [REQ1 -> (WAIT1 for loads)] -> DONE -> IDLE. FAULT -> IDLE.
- REQx:
  - mem_req=1 with addr, be and wdata stable until mem_gnt.
  - On gnt: a store moves to the next REQ or DONE; a load moves to WAITx.
- WAITx: mem_req=0. On mem_rvalid, capture mem_rdata into word register x.
- DONE:
  - done=1, stall=0.
  - rd = bytes selected starting at offset a[1:0] across word0:word1, then sign- or zero-extended per Funct3.
  - Returns to IDLE next cycle. The pipeline has advanced, so a request seen in IDLE is always a new one.
- Store lanes:
  - Word 0 uses be = size mask << a[1:0] and wdata = wd << 8*a[1:0].
  - Word 1 takes the overflow lanes: be = mask >> (4-a[1:0]).
  - Only the low size bytes of wd are written.
- Minimum latency (gnt same cycle, rvalid 1 cycle later):
  - Aligned load: done in cycle 3 after capture cycle 0.
  - Aligned store: done in cycle 2.
  - Split access: adds 2 cycles for a load, 1 for a store.
- Latency with a held-off grant: mem_gnt low for N cycles extends REQx by N cycles. The request must not change during that time.
- mem_rvalid outside WAITx is ignored.
- Synchronous reset in any state forces IDLE next edge and drops mem_req. A late mem_rvalid after reset is ignored. No done pulse is produced.

Decomposition:
- lsu_pkg:
  - state enum (IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, FAULT);
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - size-decode function (Funct3 -> 1/2/4 bytes, legal flag).
- Sub-module lsu_align: combinational load merge/extend and store lane shift/byte-enable generation. The FSM stays in load_store_unit.

Test Plan:
- Aligned LW at a=0x010, memory word 0x8001_7FFE, gnt immediate -> one transaction, mem_addr=0x010, rd=0x8001_7FFE, done 3 cycles after capture.
- LB at a=0x013 with word 0x80xx_xxxx -> rd=0xFFFF_FF80. LBU at the same address -> rd=0x0000_0080.
- Misaligned LW at a=0x0FE, words [0x0FC]=0xBBAA_xxxx and [0x100]=0xxxxx_DDCC -> two reads (0x0FC, 0x100), rd=0xDDCC_BBAA.
- SH at a=0x1FF (DM_ADDRESS=9), wd=0x1234_5678 -> write 0x1FC with be=1000 and wdata[31:24]=0x78, then write 0x000 with be=0001 and wdata[7:0]=0x56 (wrap-around case).
- SB at a=0x005 with mem_gnt held low 3 cycles -> mem_req, addr, be=0010 and wdata=0x0000_xx00 stable throughout; stall high until done.
- Reset asserted in WAIT1 of a split load -> IDLE next cycle, mem_req=0, stall=0, no done. Funct3=011 load -> err=1, no mem_req.
